// File: rtl/pll_drp_master.sv
// rtl/pll_drp_master.sv - single-register read/write initiator for the PLLA DRP port with optional reset/relock.
module pll_drp_master #(
    parameter int READ_LAT     = 2,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_apply,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       mdclk,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo,
    output logic       pll_reset,
    input  logic       pll_lock
);

    localparam int TW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW  = $clog2(RST_CYCLES + 1);
    localparam int LW  = $clog2(READ_LAT + 1);
    localparam int CW0 = (TW > RW) ? TW : RW;
    localparam int CW  = (CW0 > LW) ? CW0 : LW;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ADDR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITPH,
        S_ADDR,
        S_DATA,
        S_RDWAIT,
        S_APPLY,
        S_LOCKWAIT,
        S_RESP
    } state_t;

    state_t        state;
    logic          ph;
    logic          armed;
    logic          lock_meta;
    logic          lock_sync;
    logic          seen_low;
    logic [CW-1:0] cnt;
    logic          l_write;
    logic          l_apply;
    logic [7:0]    l_addr;
    logic [7:0]    l_wdata;

    assign mdclk  = ph;
    assign mdainc = 1'b0;

    // ph==1 before an edge means that edge is an mdclk falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ph        <= 1'b0;
            armed     <= 1'b0;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            seen_low  <= 1'b0;
            cnt       <= '0;
            l_write   <= 1'b0;
            l_apply   <= 1'b0;
            l_addr    <= 8'h00;
            l_wdata   <= 8'h00;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
            mdopc     <= OP_NOP;
            mdwdi     <= 8'h00;
            pll_reset <= 1'b0;
        end else begin
            ph        <= ~ph;
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        l_write   <= cmd_write;
                        l_apply   <= cmd_write & cmd_apply;
                        l_addr    <= cmd_addr;
                        l_wdata   <= cmd_wdata;
                        rsp_rdata <= 8'h00;
                        rsp_err   <= 1'b0;
                        armed     <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_WAITPH;
                    end
                end
                S_WAITPH: begin
                    // Skip a falling edge that arrives right after accept so ADDR always follows a full NOP half-period.
                    armed <= 1'b1;
                    if (ph && armed) begin
                        mdopc <= OP_ADDR;
                        mdwdi <= l_addr;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ph) begin
                        mdopc <= l_write ? OP_WRITE : OP_READ;
                        mdwdi <= l_write ? l_wdata : 8'h00;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (ph) begin
                        mdopc <= OP_NOP;
                        mdwdi <= 8'h00;
                        cnt   <= '0;
                        if (!l_write) begin
                            state <= S_RDWAIT;
                        end else if (l_apply) begin
                            pll_reset <= 1'b1;
                            state     <= S_APPLY;
                        end else begin
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end
                end
                S_RDWAIT: begin
                    if (ph) begin
                        if (cnt == CW'(READ_LAT - 1)) begin
                            rsp_rdata <= mdrdo;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_APPLY: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        pll_reset <= 1'b0;
                        cnt       <= '0;
                        seen_low  <= 1'b0;
                        state     <= S_LOCKWAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOCKWAIT: begin
                    // A lock that never dropped is stale and must not complete the apply.
                    if (!lock_sync) begin
                        seen_low <= 1'b1;
                    end
                    if (lock_sync && seen_low) begin
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt == CW'(LOCK_TIMEOUT)) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
